data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder that services the memory side of the single-cycle CPU's data port: `mem_addr`, `mem_write_data`, `mem_wr`, `sh`, `sb` in, `mem_read_data` out. It holds a word-organised RAM with byte-lane write masking and returns load data lane-aligned for write-back extraction. After reset it sweeps the RAM to zero while asserting `busy`; the top level holds the CPU in reset while `busy` is high. It also records sticky misalignment and out-of-range error flags.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two, at least 4.
- `AW`, `$clog2(DEPTH)`: word-index width.

- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high.
- `mem_addr` input 32: byte address from the CPU ALU result.
- `mem_write_data` input 32: store data, right-justified: byte in [7:0], halfword in [15:0].
- `mem_wr` input 1: store request this cycle.
- `sh` input 1: halfword store.
- `sb` input 1: byte store. If both `sh` and `sb` are asserted, `sb` wins.
- `mem_read_data` output 32: load data, rotated so the addressed byte is in [7:0].
- `busy` output 1: clear sweep in progress.
- `misalign_err` output 1: sticky; a misaligned store was rejected.
- `oob_err` output 1: sticky; an out-of-range access was seen.

## Operation
- Little-endian lanes: lane k is bits [8k+7:8k]. Word index is `mem_addr[AW+1:2]`; offset is `mem_addr[1:0]`.
- An address is in range when `mem_addr[31:AW+2] == 0`.
- FSM has two states, CLEAR and READY.
  - Reset enters CLEAR with `clr_idx` = 0.
  - Each CLEAR cycle writes 0 to word `clr_idx` and increments it.
  - The cycle that writes word DEPTH-1 transitions to READY.
  - READY is terminal until the next reset.
- `busy` = (state == CLEAR). While busy: CPU stores are ignored, `mem_read_data` = 0, and error flags do not update.
- Stores are evaluated in READY only, on each rising edge while `mem_wr` = 1.
  - Word store (no `sh`/`sb`): requires offset 0; writes all lanes with `mem_write_data`.
  - Halfword store: requires `offset[0]` = 0; writes lanes {off, off+1} with `mem_write_data[15:0]`.
  - Byte store: writes lane off with `mem_write_data[7:0]`.
  - A misaligned store writes nothing and sets `misalign_err`.
  - An out-of-range store writes nothing and sets `oob_err`. If a store is both, both flags set.
- Reads are combinational from `mem_addr` at all times in READY.
  - `mem_read_data` = RAM[index] rotated right by 8*offset.
  - An out-of-range address returns 0 and sets `oob_err` at the next edge, whether or not `mem_wr` is asserted.
- Error flags clear only on reset.

## Timing
- Reset values: state CLEAR, `clr_idx` 0, `busy` 1, `misalign_err` 0, `oob_err` 0, `mem_read_data` 0.
- After `reset` deasserts, `busy` stays high for exactly DEPTH rising edges and falls after the DEPTH-th edge.
- Reset asserted mid-sweep returns immediately to CLEAR with `clr_idx` 0. The sweep restarts from word 0.
- Store latency is one edge: data written at edge N is visible on `mem_read_data` combinationally after edge N.
- Read and write to the same word in one cycle: `mem_read_data` shows the old contents before the edge and the new contents after it. There is no forwarding.
- The CPU is single-cycle, so there is no request/acknowledge handshake. Every READY cycle is a complete transaction.

## Structure
- Shared constants header holds lane width (8), lane count (4), and FSM state encodings (CLEAR=1'b0, READY=1'b1).
- One sub-module, `store_lane_mask`, maps (`sb`, `sh`, offset) to a 4-bit lane enable, a placed 32-bit write word, and a misaligned flag. It is purely combinational.
- The top holds the RAM array, FSM, clear counter, read rotator, and sticky flags.

## Test plan
- Assert reset, release, count edges: `busy` = 1 for exactly 1024 edges. Reading any in-range address during the sweep gives 0; reading one after the sweep gives 0.
- Word store 0xDEADBEEF to 0x10, then halfword 0x1234 to 0x12: read 0x10 = 0x1234BEEF, and read 0x12 = 0xBEEF1234.
- Byte store 0xAB to 0x13 over 0x1234BEEF: read 0x10 = 0xAB34BEEF, and read 0x13 = 0x34BEEFAB.
- Halfword store to 0x11 and word store to 0x22: memory unchanged and `misalign_err` = 1. A following aligned store succeeds and the flag stays 1.
- Store to 0x00001000 (DEPTH 1024): nothing written, read = 0, `oob_err` = 1. Pulse reset: both flags 0 and `busy` = 1.
- Pulse reset 100 cycles into the sweep, then write 0x55 to word 5 before the sweep ends: the write is ignored. `busy` stays high for 1024 edges after the second reset release, and word 5 reads 0.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_pkg
//  Description : Shared lane geometry, FSM encoding and the load-rotate helper
//                for the data-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;

    // Sweep-then-serve controller states
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Rotate a word right by whole lanes so the addressed byte lands in [7:0]
    function automatic logic [31:0] rotate_right_lanes(input logic [31:0] word,
                                                       input logic [1:0]  off);
        logic [63:0] dbl;
        dbl = {word, word} >> {off, 3'b000};
        return dbl[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_store_lane_mask.sv
`default_nettype none
// ============================================================================
//  Module      : store_lane_mask
//  Description : Maps store size and byte offset to lane enables, a lane-placed
//                write word and a misalignment indication. Combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_lane_mask
    import data_mem_responder_pkg::*;
(
    input  logic                      sb,
    input  logic                      sh,
    input  logic [1:0]                offset,
    input  logic [31:0]               write_data,
    output logic [LANES-1:0]          lane_en,
    output logic [31:0]               placed_data,
    output logic                      misaligned
);

    // Byte wins over halfword; replicate the source so any enabled lane sees it
    always_comb begin
        lane_en     = '0;
        placed_data = write_data;
        misaligned  = 1'b0;
        if (sb) begin
            lane_en     = 4'b0001 << offset;
            placed_data = {4{write_data[7:0]}};
        end else if (sh) begin
            lane_en     = offset[1] ? 4'b1100 : 4'b0011;
            placed_data = {2{write_data[15:0]}};
            misaligned  = offset[0];
        end else begin
            lane_en     = 4'b1111;
            placed_data = write_data;
            misaligned  = (offset != 2'b00);
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Word-organised data RAM for the single-cycle CPU. Zeroes the
//                array after reset (busy high), then services byte/half/word
//                stores with lane masking and lane-rotated combinational loads.
//                Sticky flags record misaligned and out-of-range accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic        mem_wr,
    input  logic        sh,
    input  logic        sb,
    output logic [31:0] mem_read_data,
    output logic        busy,
    output logic        misalign_err,
    output logic        oob_err
);

    state_t             r_state;
    state_t             w_next_state;
    logic [AW-1:0]      r_clr_idx;
    logic [AW-1:0]      w_next_clr_idx;
    logic [31:0]        r_mem [DEPTH];

    logic [AW-1:0]      w_idx;
    logic [1:0]         w_off;
    logic               w_in_range;
    logic               w_ready;
    logic [LANES-1:0]   w_lane_en;
    logic [31:0]        w_placed;
    logic               w_misaligned;
    logic               w_store_ok;

    assign w_idx      = mem_addr[AW+1:2];
    assign w_off      = mem_addr[1:0];
    assign w_in_range = (mem_addr[31:AW+2] == '0);
    assign w_ready    = (r_state == ST_READY);
    assign busy       = (r_state == ST_CLEAR);
    assign w_store_ok = w_ready && mem_wr && !w_misaligned && w_in_range;

    store_lane_mask u_store_lane_mask (
        .sb          (sb),
        .sh          (sh),
        .offset      (w_off),
        .write_data  (mem_write_data),
        .lane_en     (w_lane_en),
        .placed_data (w_placed),
        .misaligned  (w_misaligned)
    );

    // State and sweep-pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_next_state;
            r_clr_idx <= w_next_clr_idx;
        end
    end

    // Sweep advances one word per cycle and hands over after the last word
    always_comb begin
        w_next_state   = r_state;
        w_next_clr_idx = r_clr_idx;
        case (r_state)
            ST_CLEAR: begin
                w_next_clr_idx = r_clr_idx + AW'(1);
                if (r_clr_idx == AW'(DEPTH - 1)) begin
                    w_next_state = ST_READY;
                end
            end
            default: begin
                w_next_state = ST_READY;
            end
        endcase
    end

    // RAM write port: sweep zeroes take priority, CPU stores only when ready
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_store_ok) begin
            for (int k = 0; k < LANES; k++) begin
                if (w_lane_en[k]) begin
                    r_mem[w_idx][k*LANE_W +: LANE_W] <= w_placed[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Sticky error flags, updated only while serving the CPU
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_err <= 1'b0;
            oob_err      <= 1'b0;
        end else if (w_ready) begin
            if (mem_wr && w_misaligned) begin
                misalign_err <= 1'b1;
            end
            if (!w_in_range) begin
                oob_err <= 1'b1;
            end
        end
    end

    // Combinational load path; no forwarding from a same-cycle store
    always_comb begin
        mem_read_data = '0;
        if (w_ready && w_in_range) begin
            mem_read_data = rotate_right_lanes(r_mem[w_idx], w_off);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench for data_mem_responder with a byte-level
//                reference model of memory, busy window and sticky flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int DEPTH  = 1024;
    localparam int BYTES  = 4 * DEPTH;
    localparam int ABITS  = $clog2(BYTES);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_write_data = '0;
    logic        mem_wr = 1'b0;
    logic        sh = 1'b0;
    logic        sb = 1'b0;
    logic [31:0] mem_read_data;
    logic        busy;
    logic        misalign_err;
    logic        oob_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] ref_mem [BYTES];
    int         busy_left = DEPTH;
    logic       exp_mis = 1'b0;
    logic       exp_oob = 1'b0;

    data_mem_responder #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_wr         (mem_wr),
        .sh             (sh),
        .sb             (sb),
        .mem_read_data  (mem_read_data),
        .busy           (busy),
        .misalign_err   (misalign_err),
        .oob_err        (oob_err)
    );

    always #5 clk = ~clk;

    function automatic logic in_rng(input logic [31:0] a);
        return (a >> ABITS) == 0;
    endfunction

    // Little-endian byte memory viewed as a word rotated to the addressed byte
    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] r;
        int base;
        r = '0;
        if (busy_left == 0 && in_rng(a)) begin
            base = int'(a % BYTES) & ~3;
            for (int i = 0; i < 4; i++) begin
                r[8*i +: 8] = ref_mem[base + ((int'(a % 4) + i) % 4)];
            end
        end
        return r;
    endfunction

    // Advance one rising edge and apply its effect to the model
    task automatic tick();
        logic mis;
        int   n;
        @(posedge clk);
        if (reset) begin
            busy_left = DEPTH;
            exp_mis   = 1'b0;
            exp_oob   = 1'b0;
            for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (!in_rng(mem_addr)) exp_oob = 1'b1;
            if (mem_wr) begin
                if (sb)      mis = 1'b0;
                else if (sh) mis = mem_addr[0];
                else         mis = (mem_addr[1:0] != 2'b00);
                if (mis) exp_mis = 1'b1;
                if (!mis && in_rng(mem_addr)) begin
                    n = sb ? 1 : (sh ? 2 : 4);
                    for (int i = 0; i < n; i++) begin
                        ref_mem[int'(mem_addr % BYTES) + i] = mem_write_data[8*i +: 8];
                    end
                end
            end
        end
        #1;
    endtask

    task automatic set_in(input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic h, input logic b);
        @(negedge clk);
        mem_addr       = a;
        mem_write_data = d;
        mem_wr         = w;
        sh             = h;
        sb             = b;
    endtask

    // Tick until busy falls, bounded
    task automatic count_busy(output int edges);
        edges = 0;
        while (busy === 1'b1 && edges < 2*DEPTH) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        int edges;
        #2 reset = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b expected 0", misalign_err); end
        checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL reset_oob: got %b expected 0", oob_err); end
        checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h expected 0", mem_read_data); end
        @(negedge clk);
        reset = 1'b0;
        edges = 0;
        while (busy === 1'b1 && edges < 2*DEPTH) begin
            if (edges % 128 == 7) begin
                mem_addr = $urandom_range(BYTES - 1, 0);
                #1;
                checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL sweep_rd: addr %h got %h expected 0", mem_addr, mem_read_data); end
            end
            tick();
            edges++;
        end
        checks++; if (edges != DEPTH) begin errors++; $display("FAIL busy_edges: got %0d expected %0d", edges, DEPTH); end
        set_in(32'h0000_0ABC, 0, 0, 0, 0);
        #1;
        checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL post_sweep_rd: got %h expected 0", mem_read_data); end
    endtask

    task automatic test_word_half_byte();
        set_in(32'h10, 32'hDEAD_BEEF, 1, 0, 0); tick();
        set_in(32'h12, 32'h0000_1234, 1, 1, 0); tick();
        set_in(32'h10, 0, 0, 0, 0); #1;
        checks++; if (mem_read_data !== 32'h1234_BEEF) begin errors++; $display("FAIL half_rd10: got %h expected 1234beef", mem_read_data); end
        set_in(32'h12, 0, 0, 0, 0); #1;
        checks++; if (mem_read_data !== 32'hBEEF_1234) begin errors++; $display("FAIL half_rd12: got %h expected beef1234", mem_read_data); end
        set_in(32'h13, 32'h0000_00AB, 1, 0, 1); tick();
        set_in(32'h10, 0, 0, 0, 0); #1;
        checks++; if (mem_read_data !== 32'hAB34_BEEF) begin errors++; $display("FAIL byte_rd10: got %h expected ab34beef", mem_read_data); end
        set_in(32'h13, 0, 0, 0, 0); #1;
        checks++; if (mem_read_data !== 32'h34BE_EFAB) begin errors++; $display("FAIL byte_rd13: got %h expected 34beefab", mem_read_data); end
    endtask

    task automatic test_misalign();
        set_in(32'h11, 32'h0000_FFFF, 1, 1, 0); tick();
        set_in(32'h22, 32'hFFFF_FFFF, 1, 0, 0); tick();
        set_in(32'h10, 0, 0, 0, 0); #1;
        checks++; if (mem_read_data !== 32'hAB34_BEEF) begin errors++; $display("FAIL mis_rd10: got %h expected ab34beef", mem_read_data); end
        set_in(32'h20, 0, 0, 0, 0); #1;
        checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL mis_rd20: got %h expected 0", mem_read_data); end
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", misalign_err); end
        checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL mis_oob: got %b expected 0", oob_err); end
        set_in(32'h20, 32'h1122_3344, 1, 0, 0); tick();
        set_in(32'h20, 0, 0, 0, 0); #1;
        checks++; if (mem_read_data !== 32'h1122_3344) begin errors++; $display("FAIL mis_recover: got %h expected 11223344", mem_read_data); end
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b expected 1", misalign_err); end
    endtask

    task automatic test_oob();
        int edges;
        set_in(32'h0000_1000, 32'h5A5A_5A5A, 1, 0, 0); tick();
        set_in(32'h0000_1000, 0, 0, 0, 0); #1;
        checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL oob_rd: got %h expected 0", mem_read_data); end
        checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL oob_flag: got %b expected 1", oob_err); end
        set_in(32'h0, 0, 0, 0, 0); #1;
        checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL oob_alias: got %h expected 0", mem_read_data); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (misalign_err !== 1'b0 || oob_err !== 1'b0) begin errors++; $display("FAIL oob_reset_flags: got %b%b expected 00", misalign_err, oob_err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL oob_reset_busy: got %b expected 1", busy); end
        tick();
        @(negedge clk);
        reset = 1'b0;
        count_busy(edges);
        checks++; if (edges != DEPTH) begin errors++; $display("FAIL oob_sweep_edges: got %0d expected %0d", edges, DEPTH); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] exp;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(19, 0) == 0) a = 32'h0000_1000 + $urandom_range(4095, 0);
            else if ($urandom_range(3, 0) == 0) a = $urandom_range(BYTES - 1, 0);
            else a = $urandom_range(63, 0);
            set_in(a, $urandom, $urandom_range(1, 0) == 1,
                   $urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0);
            #1;
            exp = ref_read(a);
            checks++; if (mem_read_data !== exp) begin errors++; $display("FAIL rand_rd: addr %h got %h expected %h", a, mem_read_data, exp); end
            tick();
            checks++; if (misalign_err !== exp_mis || oob_err !== exp_oob) begin errors++; $display("FAIL rand_flags: got %b%b expected %b%b", misalign_err, oob_err, exp_mis, exp_oob); end
        end
        set_in(32'h0, 0, 0, 0, 0);
    endtask

    task automatic test_mid_sweep_reset();
        int edges;
        @(negedge clk); reset = 1'b1; tick();
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        @(negedge clk); reset = 1'b1; tick();
        @(negedge clk); reset = 1'b0;
        edges = 0;
        while (busy === 1'b1 && edges < 2*DEPTH) begin
            if (edges == 10) set_in(32'h14, 32'h0000_0055, 1, 0, 0);
            if (edges == 11) set_in(32'h14, 0, 0, 0, 0);
            tick();
            edges++;
        end
        checks++; if (edges != DEPTH) begin errors++; $display("FAIL mid_sweep_edges: got %0d expected %0d", edges, DEPTH); end
        set_in(32'h14, 0, 0, 0, 0); #1;
        checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL mid_sweep_word5: got %h expected 0", mem_read_data); end
    endtask

    initial begin
        for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_word_half_byte();
        test_misalign();
        test_oob();
        test_random();
        test_mid_sweep_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
